// File: rtl/decode_pkg.sv
// decode_pkg: shared decode-side types and MIPS opcode/funct constants.
// Holds the fetch queue entry layout and helpers for instruction fields.
package decode_pkg;

    typedef logic [31:0] word_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] F_JR       = 6'b001000;
    localparam logic [5:0] F_JALR     = 6'b001001;

    // One fetched instruction as held in the fetch queue
    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  exc;
        logic  is_branch;
    } fetch_entry_t;

    function automatic logic [5:0] instr_opcode(input word_t instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] instr_funct(input word_t instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/fetch_queue_branch_predecode.sv
// branch_predecode: combinational branch/jump classifier for one instruction.
// Flags every control-transfer instruction that owns a delay slot.
module branch_predecode
    import decode_pkg::*;
(
    input  word_t instr,
    output logic  is_branch
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = instr_opcode(instr);
    assign fn = instr_funct(instr);

    // Opcode-class match, plus register jumps encoded under SPECIAL
    always_comb begin
        is_branch = 1'b0;
        unique case (op)
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ,
            OP_REGIMM, OP_J, OP_JAL: is_branch = 1'b1;
            OP_SPECIAL:              is_branch = (fn == F_JR) || (fn == F_JALR);
            default:                 is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Predecodes branches on enqueue and reports delay-slot membership on dequeue.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency enq->deq path
// when the queue is empty.
module fetch_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [31:0]                enq_pc,
    input  logic [31:0]                enq_instr,
    input  logic                       enq_exc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_instr,
    output logic                       deq_exc,
    output logic                       deq_in_delay_slot,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_branch_q, last_branch_d;

    logic          pd_branch;
    fetch_entry_t  enq_entry;
    fetch_entry_t  head;
    logic          empty, full, bypass;
    logic          enq_fire, deq_fire, wr_en, rd_en;

    branch_predecode u_predecode (
        .instr     (enq_instr),
        .is_branch (pd_branch)
    );

    // A faulting fetch carries no meaningful instruction, so it never opens a delay slot
    always_comb begin
        enq_entry.pc        = enq_pc;
        enq_entry.instr     = enq_instr;
        enq_entry.exc       = enq_exc;
        enq_entry.is_branch = pd_branch && !enq_exc;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && enq_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign head      = bypass ? enq_entry : mem_q[rd_ptr_q];
    assign enq_ready = !full;
    assign deq_valid = !empty || bypass;
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready && !flush;
    // A bypassed entry that is consumed immediately never touches storage
    assign wr_en     = enq_fire && !(bypass && deq_ready);
    assign rd_en     = deq_fire && !bypass;

    assign deq_pc            = head.pc;
    assign deq_instr         = head.exc ? 32'h0 : head.instr;
    assign deq_exc           = head.exc;
    assign deq_in_delay_slot = last_branch_q;
    assign count             = count_q;

    // Next-state: flush wins over any same-cycle enqueue/dequeue
    always_comb begin
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        last_branch_d = last_branch_q;
        if (flush) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            last_branch_d = 1'b0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = enq_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                last_branch_d = head.is_branch;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared too so head outputs read 0 out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            last_branch_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            last_branch_q <= last_branch_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH = 8).
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_exc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_exc;
    logic        deq_in_delay_slot;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_BEQ  = 32'h10000003;
    localparam logic [31:0] I_ADDU = 32'h00851021;
    localparam logic [31:0] I_ORI  = 32'h34A50001;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_BAL  = 32'h04110002;
    localparam logic [31:0] I_JALR = 32'h0040F809;
    localparam logic [31:0] I_NOP  = 32'h00000000;

    fetch_queue #(.DEPTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_pc            (enq_pc),
        .enq_instr         (enq_instr),
        .enq_exc           (enq_exc),
        .deq_valid         (deq_valid),
        .deq_ready         (deq_ready),
        .deq_pc            (deq_pc),
        .deq_instr         (deq_instr),
        .deq_exc           (deq_exc),
        .deq_in_delay_slot (deq_in_delay_slot),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic exc);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_instr = ins;
        enq_exc   = exc;
        cyc();
        enq_valid = 1'b0;
        enq_exc   = 1'b0;
    endtask

    task automatic pop();
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc();
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL reset_delay got=%b exp=0", deq_in_delay_slot); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({deq_pc, deq_instr, deq_exc} !== 65'd0) begin failures++; $display("FAIL reset_data got=%h/%h/%b exp=0", deq_pc, deq_instr, deq_exc); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_enq3();
        push(32'hBFC00000, I_NOP, 1'b0);
        push(32'hBFC00004, I_NOP, 1'b0);
        push(32'hBFC00008, I_NOP, 1'b0);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL enq3_count got=%0d exp=3", count); end
        checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL enq3_valid got=%b exp=1", deq_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (deq_pc !== 32'hBFC00000 + 32'(4*i)) begin failures++; $display("FAIL enq3_order[%0d] got=%h exp=%h", i, deq_pc, 32'hBFC00000 + 32'(4*i)); end
            pop();
        end
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL enq3_drain got=%0d/%b exp=0/0", count, deq_valid); end
    endtask

    task automatic test_full_wrap();
        // move both pointers from 3 to 5 so the fill wraps
        for (int i = 0; i < 2; i++) begin
            push(32'h0000F000, I_NOP, 1'b0);
            pop();
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, enq_ready); end
            push(32'h00001000 + 32'(4*i), I_NOP, 1'b0);
        end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", enq_ready); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
        push(32'hFFFF0000, I_NOP, 1'b0);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ninth_count got=%0d exp=8", count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (deq_pc !== 32'h00001000 + 32'(4*i)) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, deq_pc, 32'h00001000 + 32'(4*i)); end
            pop();
        end
        checks++; if (deq_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL wrap_empty got=%b/%0d exp=0/0", deq_valid, count); end
    endtask

    task automatic test_back_to_back();
        push(32'h00005000, I_NOP, 1'b0);
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h00005004 + 32'(4*i);
            enq_instr = I_NOP;
            deq_ready = 1'b1;
            #1;
            checks++; if (deq_pc !== 32'h00005000 + 32'(4*i)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, deq_pc, 32'h00005000 + 32'(4*i)); end
            cyc();
            checks++; if (count !== 4'd1) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, count); end
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++; if (deq_pc !== 32'h0000500C) begin failures++; $display("FAIL b2b_last got=%h exp=0000500c", deq_pc); end
        pop();
    endtask

    task automatic test_delay_slot();
        push(32'h00000100, I_BEQ,  1'b0);
        push(32'h00000104, I_ADDU, 1'b0);
        push(32'h00000108, I_ORI,  1'b0);
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL ds_beq got=%b exp=0", deq_in_delay_slot); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b1 || deq_instr !== I_ADDU) begin failures++; $display("FAIL ds_addu got=%b/%h exp=1/%h", deq_in_delay_slot, deq_instr, I_ADDU); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL ds_ori got=%b exp=0", deq_in_delay_slot); end
        pop();
        push(32'h00000200, I_JR,   1'b0);
        push(32'h00000204, I_ADDU, 1'b0);
        push(32'h00000208, I_BAL,  1'b0);
        push(32'h0000020C, I_NOP,  1'b0);
        push(32'h00000210, I_JALR, 1'b0);
        push(32'h00000214, I_NOP,  1'b0);
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL ds_jr got=%b exp=0", deq_in_delay_slot); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b1) begin failures++; $display("FAIL ds_after_jr got=%b exp=1", deq_in_delay_slot); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL ds_bal got=%b exp=0", deq_in_delay_slot); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b1) begin failures++; $display("FAIL ds_after_bal got=%b exp=1", deq_in_delay_slot); end
        pop();
        pop();
        checks++; if (deq_in_delay_slot !== 1'b1) begin failures++; $display("FAIL ds_after_jalr got=%b exp=1", deq_in_delay_slot); end
        pop();
    endtask

    task automatic test_flush();
        push(32'h00006000, I_BEQ, 1'b0);
        for (int i = 1; i < 5; i++) push(32'h00006000 + 32'(4*i), I_NOP, 1'b0);
        pop();
        checks++; if (count !== 4'd4 || deq_in_delay_slot !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0d/%b exp=4/1", count, deq_in_delay_slot); end
        enq_valid = 1'b1;
        enq_pc    = 32'hDEAD0000;
        enq_instr = I_NOP;
        deq_ready = 1'b1;
        flush     = 1'b1;
        cyc();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", deq_valid); end
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL flush_delay got=%b exp=0", deq_in_delay_slot); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", enq_ready); end
        push(32'h00007000, I_NOP, 1'b0);
        checks++; if (deq_pc !== 32'h00007000 || count !== 4'd1) begin failures++; $display("FAIL flush_after got=%h/%0d exp=00007000/1", deq_pc, count); end
        pop();
    endtask

    task automatic test_exc();
        push(32'h00003000, I_BEQ,  1'b1);
        push(32'h00003004, I_ADDU, 1'b0);
        checks++; if (deq_exc !== 1'b1 || deq_instr !== 32'h0 || deq_pc !== 32'h00003000) begin failures++; $display("FAIL exc_head got=%b/%h/%h exp=1/00000000/00003000", deq_exc, deq_instr, deq_pc); end
        pop();
        checks++; if (deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL exc_next_delay got=%b exp=0", deq_in_delay_slot); end
        checks++; if (deq_exc !== 1'b0 || deq_instr !== I_ADDU) begin failures++; $display("FAIL exc_next_data got=%b/%h exp=0/%h", deq_exc, deq_instr, I_ADDU); end
        pop();
    endtask

    task automatic test_latency();
        enq_valid = 1'b1;
        enq_pc    = 32'h00004000;
        enq_instr = I_NOP;
        deq_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h00004000) begin failures++; $display("FAIL bypass_same got=%b/%h exp=1/00004000", deq_valid, deq_pc); end
        cyc();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL bypass_after got=%0d/%b exp=0/0", count, deq_valid); end
`else
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL lat_same got=%b exp=0", deq_valid); end
        cyc();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h00004000 || count !== 4'd1) begin failures++; $display("FAIL lat_next got=%b/%h/%0d exp=1/00004000/1", deq_valid, deq_pc, count); end
        pop();
`endif
    endtask

    task automatic test_reset_mid();
        push(32'h00008000, I_BEQ, 1'b0);
        push(32'h00008004, I_NOP, 1'b0);
        pop();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0 || deq_in_delay_slot !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%b/%b exp=0/0/0", count, deq_valid, deq_in_delay_slot); end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_instr = '0;
        enq_exc   = 1'b0;
        deq_ready = 1'b0;
        test_reset();
        test_enq3();
        test_full_wrap();
        test_back_to_back();
        test_delay_slot();
        test_flush();
        test_exc();
        test_latency();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decoder. It holds fetched `{pc, instr, fetch-exception}` entries in a circular FIFO and decouples I-cache latency from decode stalls. On enqueue it predecodes each instruction's branch/jump class. On dequeue it produces the `in_delay_slot` flag that the decoder forwards into `decode_data_t`. Redirects and exceptions flush it.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all entries and clear delay-slot tracking.
- `enq_valid`  in  1  fetch presents an entry.
- `enq_ready`  out  1  queue can accept an entry; equals `!full`.
- `enq_pc`  in  32  PC of the fetched instruction.
- `enq_instr`  in  32  raw instruction word.
- `enq_exc`  in  1  fetch address error (AdEL on instruction fetch).
- `deq_valid`  out  1  head entry available.
- `deq_ready`  in  1  decoder consumes the head this cycle.
- `deq_pc`  out  32  head PC.
- `deq_instr`  out  32  head instruction. Forced to `32'h0` when `deq_exc` is 1.
- `deq_exc`  out  1  head fetch exception.
- `deq_in_delay_slot`  out  1  head follows a branch/jump in program order.
- `count`  out  $clog2(DEPTH)+1  occupancy, for perf counters and debug.

## Operation
- Storage: `DEPTH` entries of `fetch_entry_t`. Read pointer and write pointer are each `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0. `count` is held explicitly.
- Enqueue fires on `enq_valid && enq_ready && !flush`. The entry is written at the write pointer and the write pointer increments.
- Predecode on enqueue sets `is_branch` = 1 when either of these holds:
  - opcode ∈ {BEQ, BNE, BGTZ, BLEZ, REGIMM (000001), J, JAL};
  - opcode = 000000 and funct ∈ {JR, JALR}.
  - An entry with `enq_exc` = 1 stores `is_branch` = 0.
- Dequeue fires on `deq_valid && deq_ready && !flush`. The read pointer increments.
- `last_branch` register: on each dequeue it loads the head's `is_branch`. It is cleared by reset and by flush.
- `deq_in_delay_slot` = `last_branch`.
- Same-cycle enqueue and dequeue: `count` is unchanged and both pointers advance.
- Full: `enq_ready` = 0. It does not look ahead at `deq_ready`, so there is no combinational ready path.
- Empty: `deq_valid` = 0 and `deq_*` data are don't-care. The exception is bypass mode (see Configuration).
- Flush has priority over enqueue and dequeue in the same cycle:
  - both pointers, `count` and `last_branch` go to 0;
  - any enqueue or dequeue in that cycle is dropped.
- The control unit raises flush only after a branch's delay slot has been dequeued, so no delay-slot state has to survive a flush.

## Timing
- Reset values: `enq_ready` = 1, `deq_valid` = 0, `deq_in_delay_slot` = 0, `count` = 0, `deq_pc`/`deq_instr`/`deq_exc` = 0.
- Enqueue-to-dequeue latency: 1 cycle without bypass. An entry written at edge N is visible as `deq_valid` after edge N.
- Throughput: 1 entry per cycle in each direction, including when full with a simultaneous dequeue (the slot frees at the edge and `enq_ready` rises the next cycle).
- `flush` takes effect at the next edge. After it: `deq_valid` = 0, `enq_ready` = 1.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Entries are lost.

## Configuration
- Macro `FETCH_QUEUE_BYPASS_EN`.
- Defined: when the queue is empty, `enq_valid` = 1 and `flush` = 0:
  - `deq_valid` = 1 and `deq_*` come combinationally from `enq_*`;
  - `is_branch` comes from the live predecode;
  - if `deq_ready` = 1, nothing is written and `last_branch` updates;
  - if `deq_ready` = 0, the entry is written normally.
  - Latency is 0 cycles.
- Undefined: no combinational enq→deq path. Minimum latency is 1 cycle.

## Structure
- Add `fetch_entry_t {word_t pc; word_t instr; logic exc; logic is_branch;}` to `decode_pkg`.
- Reuse the existing `OP_*` and `F_*` constants in `decode_pkg`. Add `OP_REGIMM = 6'b000001` alongside them.
- One sub-module, `branch_predecode`: purely combinational, 32-bit instruction in, `is_branch` out. It is also reusable by a future branch predictor.

## Test plan
- Reset, then enqueue 3 entries with no dequeue (PCs `0xBFC00000`, `0xBFC00004`, `0xBFC00008`) → `count` = 3, `deq_pc` = `0xBFC00000`, `deq_valid` = 1.
- Fill to `DEPTH` = 8 with `deq_ready` = 0 → `enq_ready` = 0 and the 9th entry is not written. Dequeue 8 entries → PCs come out in order, including across the pointer wrap after pre-offsetting the pointers by 5.
- Enqueue `BEQ` (`0x10000003`), then `ADDU`, then `ORI` → `deq_in_delay_slot` is 0, 1, 0 respectively. Repeat with `JR $ra` (`0x03E00008`) → the entry after it shows 1.
- Assert flush in the same cycle as `enq_valid` and `deq_ready` with 4 entries queued → next cycle `count` = 0, `deq_valid` = 0, `deq_in_delay_slot` = 0, and the enqueued entry is absent.
- Enqueue with `enq_exc` = 1 and instr `0x10000003` → `deq_exc` = 1, `deq_instr` = 0, and the following entry's `deq_in_delay_slot` = 0.
- With `FETCH_QUEUE_BYPASS_EN`: empty queue, `enq_valid` = 1, `deq_ready` = 1 → `deq_pc` equals `enq_pc` in the same cycle and `count` stays 0. Without the macro → `deq_valid` first rises one cycle later.
